// File: rtl/uart_pkg.sv
// Shared types, limits and helpers for the UART receive/transmit core.
package uart_pkg;

    localparam int unsigned MIN_BIT_RATE  = 4;
    localparam int unsigned MIN_DATA_BITS = 5;
    localparam int unsigned MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic logic [15:0] clamp_rate(input logic [15:0] rate);
        return (rate < 16'(MIN_BIT_RATE)) ? 16'(MIN_BIT_RATE) : rate;
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] nbits);
        if (nbits < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
        if (nbits > 4'(MAX_DATA_BITS)) return 4'(MAX_DATA_BITS);
        return nbits;
    endfunction

    // XOR of the low nbits data bits, inverted for odd parity.
    function automatic logic calc_parity(input logic [7:0] data, input logic [3:0] nbits,
                                         input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_txrx_core_bit_timer.sv
// Bit-period down-counter: reload with a full or half period, tick on zero, auto-reload full.
module uart_bit_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        half_i,
    input  logic        en_i,
    input  logic [15:0] period_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = half_i ? ((period_i >> 1) - 16'd1) : (period_i - 16'd1);
        end else if (en_i) begin
            cnt_d = (cnt_q == 16'd0) ? (period_i - 16'd1) : (cnt_q - 16'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_txrx_core.sv
// Full-duplex UART engine with runtime frame format.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_txrx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bit_rate,
    input  logic [3:0]  data_bits,
    input  logic [1:0]  stop_bits,
    input  logic        parity_bit,
    input  logic        parity_enabled,
    input  logic        parity_accept_errors,
    input  logic        rxd,
    output logic        rxd_syn,
    output logic [7:0]  rxd_data,
    input  logic        rxd_ack,
    output logic [2:0]  rxd_state,
    output logic        txd,
    input  logic        txd_syn,
    input  logic [7:0]  txd_data,
    output logic        txd_ack
);

    // reset_n is active-high despite its name.
    logic rst;
    assign rst = reset_n;

    logic        par_en_in, par_odd_in, par_accept_in;
    logic [15:0] rate_in;
    logic [3:0]  nbits_in;

    assign rate_in  = clamp_rate(bit_rate);
    assign nbits_in = clamp_bits(data_bits);

`ifdef UART_PARITY_EN
    assign par_en_in     = parity_enabled;
    assign par_odd_in    = parity_bit;
    assign par_accept_in = parity_accept_errors;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = ^{parity_enabled, parity_bit, parity_accept_errors};
    assign par_en_in     = 1'b0;
    assign par_odd_in    = 1'b0;
    assign par_accept_in = 1'b0;
`endif

    // ---------------- receiver ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [15:0] rx_rate_q, rx_rate_d;
    logic [3:0]  rx_nbits_q, rx_nbits_d;
    logic        rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic        rx_accept_q, rx_accept_d, rx_par_bad_q, rx_par_bad_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rxd_data_q, rxd_data_d;
    logic        rxd_syn_q, rxd_syn_d;
    logic        rx_load, rx_half, rx_en, rx_tick, rx_fall;
    logic [15:0] rx_period;

    assign rx_fall   = rx_prev_q & ~rx_sync2_q;
    assign rx_en     = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_IDLE);
    assign rx_period = (rx_state_q == RX_IDLE) ? rate_in : rx_rate_q;

    uart_bit_timer u_rx_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (rx_load),
        .half_i   (rx_half),
        .en_i     (rx_en),
        .period_i (rx_period),
        .tick_o   (rx_tick)
    );

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_rate_d    = rx_rate_q;
        rx_nbits_d   = rx_nbits_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_accept_d  = rx_accept_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_cnt_d     = rx_cnt_q;
        rx_shift_d   = rx_shift_q;
        rxd_data_d   = rxd_data_q;
        rxd_syn_d    = rxd_syn_q & ~rxd_ack;
        rx_load      = 1'b0;
        rx_half      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d   = RX_START;
                    rx_load      = 1'b1;
                    rx_half      = 1'b1;
                    rx_rate_d    = rate_in;
                    rx_nbits_d   = nbits_in;
                    rx_par_en_d  = par_en_in;
                    rx_par_odd_d = par_odd_in;
                    rx_accept_d  = par_accept_in;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_sync2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d   = RX_DATA;
                        rx_cnt_d     = 3'd0;
                        rx_shift_d   = 8'd0;
                        rx_par_bad_d = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d[rx_cnt_q] = rx_sync2_q;
                    if ({1'b0, rx_cnt_q} == rx_nbits_q - 4'd1)
                        rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    else
                        rx_cnt_d = rx_cnt_q + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_bad_d = rx_sync2_q ^ calc_parity(rx_shift_q, rx_nbits_q, rx_par_odd_q);
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (!rx_sync2_q) begin
                        rx_state_d = RX_WAIT_IDLE;
                    end else begin
                        rx_state_d = RX_IDLE;
                        // A new byte wins over a same-cycle ack and overwrites unread data.
                        if (!rx_par_bad_q || rx_accept_q) begin
                            rxd_data_d = rx_shift_q;
                            rxd_syn_d  = 1'b1;
                        end
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_q   <= 1'b1;
            rx_sync2_q   <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_rate_q    <= 16'(MIN_BIT_RATE);
            rx_nbits_q   <= 4'(MAX_DATA_BITS);
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_accept_q  <= 1'b0;
            rx_par_bad_q <= 1'b0;
            rx_cnt_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            rxd_data_q   <= 8'd0;
            rxd_syn_q    <= 1'b0;
        end else begin
            rx_sync1_q   <= rxd;
            rx_sync2_q   <= rx_sync1_q;
            rx_prev_q    <= rx_sync2_q;
            rx_state_q   <= rx_state_d;
            rx_rate_q    <= rx_rate_d;
            rx_nbits_q   <= rx_nbits_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_accept_q  <= rx_accept_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rxd_data_q   <= rxd_data_d;
            rxd_syn_q    <= rxd_syn_d;
        end
    end

    assign rxd_syn   = rxd_syn_q;
    assign rxd_data  = rxd_data_q;
    assign rxd_state = rx_state_q;

    // ---------------- transmitter ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_rate_q, tx_rate_d;
    logic [3:0]  tx_nbits_q, tx_nbits_d;
    logic        tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic        tx_two_stop_q, tx_two_stop_d, tx_stop_cnt_q, tx_stop_cnt_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_tick, tx_en, tx_accept, tx_last_stop;
    logic [15:0] tx_period;

    assign tx_last_stop = (tx_stop_cnt_q == tx_two_stop_q);
    // Accepting on the final stop tick keeps back-to-back frames gapless.
    assign tx_accept    = ~rst & txd_syn &
                          ((tx_state_q == TX_IDLE) ||
                           ((tx_state_q == TX_STOP) && tx_tick && tx_last_stop));
    assign tx_en        = (tx_state_q != TX_IDLE);
    assign tx_period    = tx_accept ? rate_in : tx_rate_q;

    uart_bit_timer u_tx_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (tx_accept),
        .half_i   (1'b0),
        .en_i     (tx_en),
        .period_i (tx_period),
        .tick_o   (tx_tick)
    );

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_rate_d     = tx_rate_q;
        tx_nbits_d    = tx_nbits_q;
        tx_par_en_d   = tx_par_en_q;
        tx_par_d      = tx_par_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_stop_cnt_d = tx_stop_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        tx_data_d     = tx_data_q;
        case (tx_state_q)
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if ({1'b0, tx_cnt_q} == tx_nbits_q - 4'd1) begin
                        tx_state_d    = tx_par_en_q ? TX_PARITY : TX_STOP;
                        tx_stop_cnt_d = 1'b0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d    = TX_STOP;
                    tx_stop_cnt_d = 1'b0;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_last_stop) tx_state_d = TX_IDLE;
                    else              tx_stop_cnt_d = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_accept) begin
            tx_state_d    = TX_START;
            tx_rate_d     = rate_in;
            tx_nbits_d    = nbits_in;
            tx_par_en_d   = par_en_in;
            tx_par_d      = calc_parity(txd_data, nbits_in, par_odd_in);
            tx_two_stop_d = stop_bits[1];
            tx_data_d     = txd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_rate_q     <= 16'(MIN_BIT_RATE);
            tx_nbits_q    <= 4'(MAX_DATA_BITS);
            tx_par_en_q   <= 1'b0;
            tx_par_q      <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_stop_cnt_q <= 1'b0;
            tx_cnt_q      <= 3'd0;
            tx_data_q     <= 8'd0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_rate_q     <= tx_rate_d;
            tx_nbits_q    <= tx_nbits_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_q      <= tx_par_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_stop_cnt_q <= tx_stop_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_data_q     <= tx_data_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state_q)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_data_q[tx_cnt_q];
            TX_PARITY: txd = tx_par_q;
            default:   txd = 1'b1;
        endcase
    end

    assign txd_ack = tx_accept;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed bench for uart_txrx_core: RX vector table plus TX, framing, glitch, reset and loopback sequences.
module tb_uart_txrx_core;

`ifdef UART_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] bit_rate = 16'd16;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  stop_bits = 2'd0;
    logic        parity_bit = 1'b0;
    logic        parity_enabled = 1'b0;
    logic        parity_accept_errors = 1'b0;
    logic        rxd;
    logic        rxd_bit = 1'b1;
    logic        lb = 1'b0;
    logic        rxd_syn;
    logic [7:0]  rxd_data;
    logic        rxd_ack = 1'b0;
    logic [2:0]  rxd_state;
    logic        txd;
    logic        txd_syn = 1'b0;
    logic [7:0]  txd_data = 8'd0;
    logic        txd_ack;

    int checks = 0;
    int errors = 0;

    assign rxd = lb ? txd : rxd_bit;

    always #5 clk = ~clk;

    uart_txrx_core dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .bit_rate             (bit_rate),
        .data_bits            (data_bits),
        .stop_bits            (stop_bits),
        .parity_bit           (parity_bit),
        .parity_enabled       (parity_enabled),
        .parity_accept_errors (parity_accept_errors),
        .rxd                  (rxd),
        .rxd_syn              (rxd_syn),
        .rxd_data             (rxd_data),
        .rxd_ack              (rxd_ack),
        .rxd_state            (rxd_state),
        .txd                  (txd),
        .txd_syn              (txd_syn),
        .txd_data             (txd_data),
        .txd_ack              (txd_ack)
    );

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  db;
        logic [1:0]  sb;
        logic [15:0] br;
        bit          pen, podd, pacc, flip;
        int          nb_line, br_line, nstop;
        bit          exp_syn;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd_bit = v;
        cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input int br, input bit par_inc,
                              input logic par_val, input logic stop0, input int nstop);
        drive_bit(1'b0, br);
        for (int i = 0; i < nb; i++) drive_bit(d[i], br);
        if (par_inc) drive_bit(par_val, br);
        drive_bit(stop0, br);
        for (int i = 1; i < nstop; i++) drive_bit(1'b1, br);
    endtask

    task automatic do_ack();
        rxd_ack = 1'b1;
        cycles(1);
        rxd_ack = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] br, input logic [3:0] db, input logic [1:0] sb,
                           input bit pen, input bit podd, input bit pacc);
        bit_rate = br; data_bits = db; stop_bits = sb;
        parity_enabled = pen; parity_bit = podd; parity_accept_errors = pacc;
    endtask

    task automatic run_loopback();
        logic [7:0] tx_bytes[3];
        logic [7:0] exp_bytes[3];
        logic [7:0] got[$];
        tx_bytes  = '{8'h00, 8'hFF, 8'h12};
        exp_bytes = '{8'h00, 8'h1F, 8'h12};
        set_cfg(16'd8, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0);
        lb = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int n;
                    n = 0;
                    txd_data = tx_bytes[i];
                    txd_syn  = 1'b1;
                    #1;
                    while (!txd_ack && n < 400) begin @(posedge clk); #1; n++; end
                    if (n >= 400) begin
                        checks++; errors++;
                        $display("FAIL lb_ack_timeout: got no ack expected ack for byte %0d", i);
                    end
                    @(posedge clk); #1;
                end
                txd_syn = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (got.size() < 3 && n < 1500) begin
                    if (rxd_syn) begin
                        got.push_back(rxd_data);
                        do_ack();
                    end else begin
                        cycles(1);
                    end
                    n++;
                end
            end
        join
        lb = 1'b0;
        chk("lb_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("lb_byte%0d", i), got[i], exp_bytes[i]);
        cycles(20);
        chk("lb_no_extra", rxd_syn, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 4'd8,  2'd0, 16'd16, 0, 0, 0, 0, 8, 16, 1, 1'b1,       8'hA5};
        vecs[1] = '{8'h35, 4'd7,  2'd2, 16'd16, 1, 0, 0, 0, 7, 16, 2, 1'b1,       8'h35};
        vecs[2] = '{8'h35, 4'd7,  2'd2, 16'd16, 1, 0, 0, 1, 7, 16, 2, !PAR_BUILD, 8'h35};
        vecs[3] = '{8'h35, 4'd7,  2'd2, 16'd16, 1, 0, 1, 1, 7, 16, 2, 1'b1,       8'h35};
        vecs[4] = '{8'hFF, 4'd5,  2'd1, 16'd8,  0, 0, 0, 0, 5, 8,  1, 1'b1,       8'h1F};
        vecs[5] = '{8'h2A, 4'd3,  2'd0, 16'd8,  0, 0, 0, 0, 5, 8,  1, 1'b1,       8'h0A};
        vecs[6] = '{8'hC3, 4'd15, 2'd0, 16'd8,  0, 0, 0, 0, 8, 8,  1, 1'b1,       8'hC3};
        vecs[7] = '{8'h96, 4'd8,  2'd0, 16'd1,  0, 0, 0, 0, 8, 4,  1, 1'b1,       8'h96};
        vecs[8] = '{8'h2D, 4'd6,  2'd0, 16'd12, 1, 1, 0, 0, 6, 12, 1, 1'b1,       8'h2D};
        vecs[9] = '{8'h00, 4'd8,  2'd3, 16'd6,  0, 0, 0, 0, 8, 6,  2, 1'b1,       8'h00};

        // Reset state
        cycles(3);
        chk("rst_txd", txd, 1'b1);
        chk("rst_txd_ack", txd_ack, 1'b0);
        chk("rst_rxd_syn", rxd_syn, 1'b0);
        chk("rst_rxd_data", rxd_data, 8'h00);
        chk("rst_rxd_state", rxd_state, 3'd0);
        reset_n = 1'b0;
        cycles(4);

        // RX vector table
        for (int i = 0; i < 10; i++) begin
            logic [7:0] mask;
            logic       pv;
            set_cfg(vecs[i].br, vecs[i].db, vecs[i].sb, vecs[i].pen, vecs[i].podd, vecs[i].pacc);
            mask = 8'((9'd1 << vecs[i].nb_line) - 9'd1);
            pv   = (^(vecs[i].d & mask)) ^ vecs[i].podd ^ vecs[i].flip;
            send_frame(vecs[i].d, vecs[i].nb_line, vecs[i].br_line,
                       PAR_BUILD && vecs[i].pen, pv, 1'b1, vecs[i].nstop);
            cycles(8);
            chk($sformatf("v%0d_syn", i), rxd_syn, vecs[i].exp_syn);
            if (vecs[i].exp_syn) chk($sformatf("v%0d_data", i), rxd_data, vecs[i].exp_data);
            do_ack();
            chk($sformatf("v%0d_syn_clr", i), rxd_syn, 1'b0);
            chk($sformatf("v%0d_state", i), rxd_state, 3'd0);
            cycles(4);
        end

        // Framing error: stop bit low, line held low
        set_cfg(16'd16, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 16, 1'b0, 1'b0, 1'b0, 1);
        cycles(8);
        chk("frm_state_wait", rxd_state, 3'd5);
        chk("frm_no_syn", rxd_syn, 1'b0);
        rxd_bit = 1'b1;
        cycles(5);
        chk("frm_state_idle", rxd_state, 3'd0);
        send_frame(8'h81, 8, 16, 1'b0, 1'b0, 1'b1, 1);
        cycles(8);
        chk("frm_next_syn", rxd_syn, 1'b1);
        chk("frm_next_data", rxd_data, 8'h81);
        do_ack();

        // Start glitch of two cycles
        rxd_bit = 1'b0;
        cycles(2);
        rxd_bit = 1'b1;
        cycles(2);
        chk("glitch_start", rxd_state, 3'd1);
        cycles(20);
        chk("glitch_idle", rxd_state, 3'd0);
        chk("glitch_no_syn", rxd_syn, 1'b0);

        // Overrun: second byte overwrites unread first
        set_cfg(16'd8, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 8, 8, 1'b0, 1'b0, 1'b1, 1);
        cycles(8);
        send_frame(8'h22, 8, 8, 1'b0, 1'b0, 1'b1, 1);
        cycles(8);
        chk("ovr_syn", rxd_syn, 1'b1);
        chk("ovr_data", rxd_data, 8'h22);
        do_ack();

        // TX 0x5A, 8O1, bit_rate 10
        begin
            logic exp_bits[$];
            int   nbits;
            int   bad;
            logic [7:0] tv;
            tv = 8'h5A;
            set_cfg(16'd10, 4'd8, 2'd0, 1'b1, 1'b1, 1'b0);
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(tv[i]);
            if (PAR_BUILD) exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b1);
            nbits = exp_bits.size();
            txd_data = tv;
            txd_syn  = 1'b1;
            #1;
            chk("tx_ack_pulse", txd_ack, 1'b1);
            chk("tx_idle_high", txd, 1'b1);
            @(posedge clk); #1;
            txd_syn = 1'b0;
            #1;
            chk("tx_ack_single", txd_ack, 1'b0);
            bad = 0;
            for (int c = 0; c < nbits * 10; c++) begin
                if (txd !== exp_bits[c / 10]) begin
                    if (bad < 4)
                        $display("FAIL tx_bit%0d_cyc%0d: got %0b expected %0b", c / 10, c, txd, exp_bits[c / 10]);
                    bad++;
                end
                if (txd_ack !== 1'b0) bad++;
                cycles(1);
                #1;
            end
            checks++;
            if (bad != 0) errors++;
            chk("tx_end_high", txd, 1'b1);
            cycles(10);
            chk("tx_stays_idle", txd, 1'b1);
        end

        // Reset mid-frame aborts both directions
        set_cfg(16'd16, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        txd_data = 8'h00;
        txd_syn  = 1'b1;
        rxd_bit  = 1'b0;
        cycles(1);
        txd_syn = 1'b0;
        cycles(47);
        chk("mid_rx_data_state", rxd_state, 3'd2);
        chk("mid_tx_low", txd, 1'b0);
        reset_n = 1'b1;
        rxd_bit = 1'b1;
        cycles(1);
        reset_n = 1'b0;
        chk("mid_rst_state", rxd_state, 3'd0);
        chk("mid_rst_txd", txd, 1'b1);
        cycles(200);
        chk("mid_rst_no_syn", rxd_syn, 1'b0);
        chk("mid_rst_txd_idle", txd, 1'b1);

        // Loopback back-to-back 5N1
        run_loopback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_txrx_core.md
# uart_txrx_core

Full-duplex, runtime-configurable UART engine: one receiver and one transmitter sharing a single clock and a common frame format (data width, stop bits, parity). It sits between a byte-level host interface (request/acknowledge handshakes) and the serial `rxd`/`txd` pins, and is used by trace-capture logic to decode target serial traffic.

## Interface
Parameters:
- none. All frame settings are runtime inputs.

Ports:
- `clk` in 1: the only clock.
- `reset_n` in 1: synchronous reset, **active-high**. The name is kept for codebase compatibility.
- `bit_rate` in 16: clock cycles per bit. Values below 4 are treated as 4.
- `data_bits` in 4: data bits per frame, valid 5..8. Values below 5 are treated as 5; values above 8 are treated as 8.
- `stop_bits` in 2: 0 or 1 selects 1 stop bit; 2 or 3 selects 2 stop bits.
- `parity_bit` in 1: 0 = even parity, 1 = odd parity.
- `parity_enabled` in 1: a parity bit follows the data bits.
- `parity_accept_errors` in 1: deliver bytes even when parity is bad.
- `rxd` in 1: asynchronous serial input; idle level is 1.
- `rxd_syn` out 1: received byte valid.
- `rxd_data` out 8: received byte, LSB-aligned; unused upper bits are 0.
- `rxd_ack` in 1: host acknowledge of `rxd_syn`.
- `rxd_state` out 3: current receiver state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 WAIT_IDLE.
- `txd` out 1: serial output; idles at 1.
- `txd_syn` in 1: transmit request; `txd_data` is valid while it is high.
- `txd_data` in 8: byte to send, LSB first.
- `txd_ack` out 1: one-cycle pulse when the request is accepted.

## Operation
- Frame format on both directions: start bit (0), then `data_bits` data bits LSB first, then parity if enabled, then the stop bit(s) (1).
- Parity value: XOR of the data bits, inverted when `parity_bit` = 1.
- Configuration inputs are sampled at the start bit. Changing them mid-frame does not affect that frame.

Receiver:
- `rxd` passes through a 2-flop synchronizer before any use.
- IDLE → START on a synchronized falling edge.
- In START, the line is sampled at half a bit period (`bit_rate`>>1). If it is high, the start was a glitch: return to IDLE.
- Each later bit is sampled at its centre, i.e. every `bit_rate` cycles after the previous sample.
- State sequence: DATA (count = `data_bits`) → PARITY (only if enabled) → STOP.
- Only the first stop bit is checked.
- Stop bit sampled 0 (framing error): discard the byte and go to WAIT_IDLE, which returns to IDLE after the synchronized line is high.
- Parity mismatch with `parity_accept_errors` = 0: discard the byte. With `parity_accept_errors` = 1: deliver the byte.
- On a good frame: `rxd_data` is loaded and `rxd_syn` is set, then the receiver returns to IDLE immediately so it is ready for the next start bit.
- `rxd_syn` stays high until the first cycle `rxd_ack` is sampled high; it clears on the next edge.
- Overrun: if a new byte arrives while `rxd_syn` is still high, it overwrites `rxd_data` and `rxd_syn` stays high.

Transmitter:
- IDLE → START when `txd_syn` = 1.
- In the same edge the core latches `txd_data` and the configuration, and pulses `txd_ack`.
- Each bit (start, data, parity, stop) is driven for exactly `bit_rate` cycles; stop bits are driven 1 or 2 times as selected.
- After the last stop bit the transmitter returns to IDLE.
- `txd_syn` held high continuously sends back-to-back frames with no idle gap.

## Timing
- Reset values: `txd`=1, `txd_ack`=0, `rxd_syn`=0, `rxd_data`=0, `rxd_state`=0.
- Reset mid-frame aborts both directions immediately. No partial byte is delivered.
- RX latency: `rxd_syn` rises 1 cycle after the stop-bit centre sample, which is 2 synchronizer cycles plus (0.5 + `data_bits` + parity + 1)·`bit_rate` cycles after the falling edge on `rxd`.
- `rxd_ack` high in the same cycle that a new byte completes: the new byte wins and `rxd_syn` stays 1.
- TX: `txd` goes 0 on the cycle after the `txd_ack` pulse. Total frame length is (1 + `data_bits` + parity + stop)·`bit_rate` cycles.

## Configuration
- `UART_PARITY_EN` defined: parity generation and checking as described above.
- `UART_PARITY_EN` not defined: `parity_enabled`, `parity_bit` and `parity_accept_errors` are ignored, frames never contain a parity bit, and the PARITY state is never entered. The encoding value 3 stays reserved.

## Structure
- Shared package `uart_pkg` holds:
  - the receiver state enum (3-bit);
  - the transmitter state enum: IDLE, START, DATA, PARITY, STOP;
  - constants `MIN_BIT_RATE`=4, `MIN_DATA_BITS`=5, `MAX_DATA_BITS`=8.
- One natural sub-module, `uart_bit_timer`: a down-counter reloaded with either the full or the half bit period that emits a sample tick. One instance is used by RX and one by TX.
- Parity XOR is a function in `uart_pkg`.

## Test plan
- 8N1, `bit_rate`=16, RX byte 0xA5 → `rxd_syn`=1 with `rxd_data`=0xA5. An ack on the next cycle clears `rxd_syn`, and `rxd_state` returns to 0.
- 7E2, RX 0x35 with correct parity → `rxd_data`=0x35. The same frame with the parity bit flipped: `parity_accept_errors`=0 gives no `rxd_syn`; `parity_accept_errors`=1 gives `rxd_data`=0x35.
- RX 0x3C with the stop bit forced to 0 → no `rxd_syn`, `rxd_state`=5 until the line returns high, then 0. The next valid frame, 0x81, is received correctly.
- 2-cycle low glitch on idle `rxd` (`bit_rate`=16) → START entered, then IDLE; `rxd_syn` never rises.
- TX 0x5A, 8O1, `bit_rate`=10 → single `txd_ack` pulse, then `txd` bits 0,0,1,0,1,1,0,1,0,1,1, each 10 cycles (start, data LSB first, odd parity = 1, stop).
- Loopback `txd`→`rxd` sending 0x00, 0xFF, 0x12 back-to-back at 5N1 → received 0x00, 0x1F, 0x12 in order, with no overrun given prompt acks.
